// File: rtl/fpu_add_sequencer_if.sv
// Issue-side handshake between the issuing unit and the FP add sequencer.
interface fpu_add_sequencer_if;
  logic beg_op;
  logic ack_op;
  logic ready_o;

  modport master (output beg_op, output ack_op, input ready_o);
  modport slave  (input beg_op, input ack_op, output ready_o);
endinterface

// File: rtl/fpu_add_sequencer.sv
// Moore sequencer for the FP add/sub stage registers with bounded normalisation loop.
// Optional: define FPU_SEQ_OPCOUNT_EN to add the op_count_o completed-operation counter.
//
// state    | meaning
// IDLE     | waiting for beg_op
// LOAD_OP  | load operand registers
// EXP_CMP  | exponent compare/swap; zero operand short-cuts to FINAL
// ALIGN    | load aligned significand
// ADD      | load adder result
// NORM     | one normalising shift per cycle, bounded by MAX_NORM
// ROUND    | load rounded result; first carry-out triggers NORM_ADJ
// NORM_ADJ | single right-shift after rounding overflow
// FINAL    | load final result register
// DONE     | result valid, waiting for ack_op
module fpu_add_sequencer #(
  parameter int SHIFT_W  = 5,
  parameter int MAX_NORM = 24
) (
  input  logic               clk,
  input  logic               rst,
  fpu_add_sequencer_if.slave hs,
  input  logic               zero_flag_i,
  input  logic               norm_done_i,
  input  logic               round_ovf_i,
  output logic               load_op_o,
  output logic               load_exp_o,
  output logic               load_align_o,
  output logic               load_add_o,
  output logic               load_norm_o,
  output logic               load_round_o,
  output logic               load_final_o,
  output logic [SHIFT_W-1:0] shift_cnt_o,
  output logic               busy_o,
  output logic               norm_sat_o
`ifdef FPU_SEQ_OPCOUNT_EN
  ,
  output logic [15:0]        op_count_o
`endif
);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_LOAD_OP  = 4'd1,
    S_EXP_CMP  = 4'd2,
    S_ALIGN    = 4'd3,
    S_ADD      = 4'd4,
    S_NORM     = 4'd5,
    S_ROUND    = 4'd6,
    S_NORM_ADJ = 4'd7,
    S_FINAL    = 4'd8,
    S_DONE     = 4'd9
  } state_e;

  state_e             state_q, state_d;
  logic [SHIFT_W-1:0] shift_cnt_q, shift_cnt_d;
  logic               norm_sat_q, norm_sat_d;
  logic               pass2_q, pass2_d;
  logic               accept;
  logic               done_exit;
  logic               load_op_q, load_exp_q, load_align_q, load_add_q;
  logic               load_norm_q, load_round_q, load_final_q;
  logic               busy_q, ready_q;

  always_comb begin
    state_d     = state_q;
    shift_cnt_d = shift_cnt_q;
    norm_sat_d  = norm_sat_q;
    pass2_d     = pass2_q;
    accept      = 1'b0;
    done_exit   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (hs.beg_op) begin
          state_d = S_LOAD_OP;
          accept  = 1'b1;
        end
      end
      S_LOAD_OP: state_d = S_EXP_CMP;
      S_EXP_CMP: state_d = zero_flag_i ? S_FINAL : S_ALIGN;
      S_ALIGN:   state_d = S_ADD;
      S_ADD:     state_d = S_NORM;
      S_NORM: begin
        if (shift_cnt_q != '1) shift_cnt_d = shift_cnt_q + 1'b1;
        if (norm_done_i) begin
          state_d = S_ROUND;
        end else if (shift_cnt_q == SHIFT_W'(MAX_NORM - 1)) begin
          state_d    = S_ROUND;
          norm_sat_d = 1'b1;
        end
      end
      S_ROUND: begin
        // Only the first rounding pass may renormalise; the second cannot carry again.
        if (round_ovf_i && !pass2_q) begin
          state_d = S_NORM_ADJ;
          pass2_d = 1'b1;
        end else begin
          state_d = S_FINAL;
        end
      end
      S_NORM_ADJ: state_d = S_ROUND;
      S_FINAL:    state_d = S_DONE;
      S_DONE: begin
        if (hs.ack_op) begin
          done_exit = 1'b1;
          if (hs.beg_op) begin
            state_d = S_LOAD_OP;
            accept  = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      shift_cnt_d = '0;
      norm_sat_d  = 1'b0;
      pass2_d     = 1'b0;
    end
  end

  // Outputs are registered from the next state so they remain pure Moore decodes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      shift_cnt_q  <= '0;
      norm_sat_q   <= 1'b0;
      pass2_q      <= 1'b0;
      load_op_q    <= 1'b0;
      load_exp_q   <= 1'b0;
      load_align_q <= 1'b0;
      load_add_q   <= 1'b0;
      load_norm_q  <= 1'b0;
      load_round_q <= 1'b0;
      load_final_q <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      shift_cnt_q  <= shift_cnt_d;
      norm_sat_q   <= norm_sat_d;
      pass2_q      <= pass2_d;
      load_op_q    <= (state_d == S_LOAD_OP);
      load_exp_q   <= (state_d == S_EXP_CMP);
      load_align_q <= (state_d == S_ALIGN);
      load_add_q   <= (state_d == S_ADD);
      load_norm_q  <= (state_d == S_NORM) || (state_d == S_NORM_ADJ);
      load_round_q <= (state_d == S_ROUND);
      load_final_q <= (state_d == S_FINAL);
      busy_q       <= (state_d != S_IDLE) && (state_d != S_DONE);
      ready_q      <= (state_d == S_DONE);
    end
  end

`ifdef FPU_SEQ_OPCOUNT_EN
  logic [15:0] op_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) op_count_q <= '0;
    else if (done_exit) op_count_q <= op_count_q + 16'd1;
  end

  assign op_count_o = op_count_q;
`else
  logic unused_done_exit;
  assign unused_done_exit = done_exit;
`endif

  assign load_op_o    = load_op_q;
  assign load_exp_o   = load_exp_q;
  assign load_align_o = load_align_q;
  assign load_add_o   = load_add_q;
  assign load_norm_o  = load_norm_q;
  assign load_round_o = load_round_q;
  assign load_final_o = load_final_q;
  assign shift_cnt_o  = shift_cnt_q;
  assign busy_o       = busy_q;
  assign norm_sat_o   = norm_sat_q;
  assign hs.ready_o   = ready_q;

endmodule

// File: tb/tb_fpu_add_sequencer.sv
// Scoreboard bench for fpu_add_sequencer: expected load sequence and results queued per op.
module tb_fpu_add_sequencer;
  localparam int SHIFT_W  = 5;
  localparam int MAX_NORM = 24;

  typedef struct {
    int lat;
    int cnt;
    int sat;
    int final_cyc;
  } exp_t;

  logic clk;
  logic rst;
  logic zero_flag_i, norm_done_i, round_ovf_i;
  logic load_op_o, load_exp_o, load_align_o, load_add_o;
  logic load_norm_o, load_round_o, load_final_o;
  logic [SHIFT_W-1:0] shift_cnt_o;
  logic busy_o, norm_sat_o;
  logic [15:0] op_count;

  fpu_add_sequencer_if hs ();

  fpu_add_sequencer #(.SHIFT_W(SHIFT_W), .MAX_NORM(MAX_NORM)) dut (
    .clk          (clk),
    .rst          (rst),
    .hs           (hs),
    .zero_flag_i  (zero_flag_i),
    .norm_done_i  (norm_done_i),
    .round_ovf_i  (round_ovf_i),
    .load_op_o    (load_op_o),
    .load_exp_o   (load_exp_o),
    .load_align_o (load_align_o),
    .load_add_o   (load_add_o),
    .load_norm_o  (load_norm_o),
    .load_round_o (load_round_o),
    .load_final_o (load_final_o),
    .shift_cnt_o  (shift_cnt_o),
    .busy_o       (busy_o),
    .norm_sat_o   (norm_sat_o)
`ifdef FPU_SEQ_OPCOUNT_EN
    ,
    .op_count_o   (op_count)
`endif
  );

`ifndef FPU_SEQ_OPCOUNT_EN
  assign op_count = 16'd0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   errs   = 0;
  int   checks = 0;
  int   acks   = 0;
  exp_t sb_q[$];
  int   seq_q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [6:0] loads();
    return {load_final_o, load_round_o, load_norm_o, load_add_o,
            load_align_o, load_exp_o, load_op_o};
  endfunction

  function automatic logic [11:0] all_outs();
    return {loads(), busy_o, hs.ready_o, norm_sat_o, shift_cnt_o != 0, |op_count};
  endfunction

  // norm_at: NORM cycle (1-based) on which norm_done_i rises; 0 = never.
  // Called #1 after a rising edge; returns #1 after the ack edge.
  task automatic run_op(input bit zero, input int norm_at, input bit ovf1, input bit ovf2,
                        input bit hold_beg, input bit b2b, input bit already);
    exp_t e;
    exp_t got;
    int   ncyc, cyc, nidx, rounds, final_cyc;
    logic [6:0] expv;

    ncyc        = zero ? 0 : ((norm_at == 0) ? MAX_NORM : norm_at);
    e.cnt       = ncyc;
    e.sat       = (!zero && norm_at == 0) ? 1 : 0;
    e.lat       = zero ? 4 : (7 + ncyc + (ovf1 ? 2 : 0));
    e.final_cyc = e.lat - 1;
    sb_q.push_back(e);
    seq_q.push_back(1);
    seq_q.push_back(2);
    if (!zero) begin
      seq_q.push_back(4);
      seq_q.push_back(8);
      for (int i = 0; i < ncyc; i++) seq_q.push_back(16);
      seq_q.push_back(32);
      if (ovf1) begin
        seq_q.push_back(16);
        seq_q.push_back(32);
      end
    end
    seq_q.push_back(64);

    nidx = 0; rounds = 0; final_cyc = 0;
    cyc = already ? 1 : 0;
    if (!already) hs.beg_op = 1'b1;
    forever begin
      if (cyc > 0) begin
        if (hs.ready_o) break;
        if (seq_q.size() == 0) check("seq_len", 32'(loads()), 0);
        else begin
          expv = 7'(seq_q.pop_front());
          check("seq", 32'(loads()), 32'(expv));
        end
        if (load_final_o && final_cyc == 0) final_cyc = cyc;
        if (load_norm_o && rounds == 0) nidx++;
        if (load_round_o) rounds++;
        zero_flag_i = load_exp_o ? zero : 1'($urandom_range(1));
        norm_done_i = (load_norm_o && rounds == 0) ? (norm_at != 0 && nidx == norm_at)
                    : (load_norm_o ? 1'($urandom_range(1)) : 1'b0);
        round_ovf_i = load_round_o ? ((rounds == 1) ? ovf1 : ovf2) : 1'($urandom_range(1));
      end
      if (cyc > 100) begin
        checks++;
        errs++;
        $display("FAIL timeout: ready_o not seen after %0d cycles", cyc);
        break;
      end
      @(posedge clk);
      #1;
      cyc++;
      hs.beg_op = hold_beg;
    end

    got = sb_q.pop_front();
    check("latency", cyc, got.lat);
    check("shift_cnt", 32'(shift_cnt_o), got.cnt);
    check("norm_sat", 32'(norm_sat_o), got.sat);
    check("final_cyc", final_cyc, got.final_cyc);
    check("seq_left", seq_q.size(), 0);
    seq_q.delete();

    hs.beg_op = b2b;
    hs.ack_op = 1'b1;
    @(posedge clk);
    #1;
    acks++;
    hs.ack_op = 1'b0;
    hs.beg_op = 1'b0;
    check("ready_after_ack", 32'(hs.ready_o), 0);
    check("b2b_load_op", 32'(load_op_o), 32'(b2b));
  endtask

  initial begin
    int cyc;
    rst = 1'b0;
    hs.beg_op = 1'b0;
    hs.ack_op = 1'b0;
    zero_flag_i = 1'b0;
    norm_done_i = 1'b0;
    round_ovf_i = 1'b0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      hs.beg_op   = 1'($urandom_range(1));
      hs.ack_op   = 1'($urandom_range(1));
      zero_flag_i = 1'($urandom_range(1));
      norm_done_i = 1'($urandom_range(1));
      round_ovf_i = 1'($urandom_range(1));
      check("reset_outs", 32'(all_outs()), 0);
    end
    @(negedge clk);
    hs.beg_op = 1'b0;
    hs.ack_op = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("idle_outs", 32'(all_outs()), 0);

    run_op(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // nominal
    run_op(1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // zero shortcut
    run_op(1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);   // long normalise
    run_op(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);   // saturating normalise, back-to-back ack
    run_op(1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);   // b2b op: counters must be cleared
    run_op(1'b0, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);   // round overflow
    run_op(1'b0, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);   // second overflow ignored
    run_op(1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);   // beg_op held while busy
    run_op(1'b0, MAX_NORM, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); // done on last allowed cycle

`ifdef FPU_SEQ_OPCOUNT_EN
    check("op_count", 32'(op_count), acks);
`endif

    // Reset while normalising must kill load_norm_o immediately.
    hs.beg_op = 1'b1;
    norm_done_i = 1'b0;
    zero_flag_i = 1'b0;
    cyc = 0;
    while (!load_norm_o && cyc < 20) begin
      @(posedge clk);
      #1;
      hs.beg_op = 1'b0;
      cyc++;
    end
    check("reached_norm", 32'(load_norm_o), 1);
    #2;
    rst = 1'b0;
    #1;
    check("async_norm_drop", 32'(load_norm_o), 0);
    check("async_outs", 32'(all_outs()), 0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("no_pulse_in_reset", 32'(loads()), 0);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    run_op(1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
